// File: rtl/rx_buffer_arbiter_pkg.sv
// Shared definitions for the inband USB packet format used by the RX/TX
// buffer schedulers: packet geometry, header length field, FSM encodings.
package inband_packet_defs;

   localparam int PKT_WORDS   = 256;
   localparam int HDR_WORDS   = 4;
   localparam int MAX_PAYLOAD = PKT_WORDS - HDR_WORDS;

   // Header byte-length field position
   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_PAD,
      ST_DONE
   } state_t;

   // Byte length -> 16-bit payload words, rounded up and clamped
   function automatic logic [7:0] payload_words(input logic [8:0] len_bytes);
      logic [8:0] w;
      w = {1'b0, len_bytes[8:1]} + {8'd0, len_bytes[0]};
      if (w > 9'(MAX_PAYLOAD)) begin
         w = 9'(MAX_PAYLOAD);
      end
      return w[7:0];
   endfunction

endpackage

// File: rtl/rx_buffer_arbiter_if.sv
// Output word stream of the RX buffer arbiter towards the USB FIFO.
// master: drives o_data/o_valid/o_sop/o_eop/o_chan, samples o_ready.
interface rx_buffer_arbiter_if #(
   parameter int CHAN_L2 = 2
);

   logic [15:0]        o_data;
   logic               o_valid;
   logic               o_ready;
   logic               o_sop;
   logic               o_eop;
   logic [CHAN_L2-1:0] o_chan;

   modport master (
      output o_data,
      output o_valid,
      output o_sop,
      output o_eop,
      output o_chan,
      input  o_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      input  o_sop,
      input  o_eop,
      input  o_chan,
      output o_ready
   );

endinterface

// File: rtl/rx_buffer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping. Ports: req (requests), ptr (search start) -> gnt (index), any.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int L2 = 2
) (
   input  logic [N-1:0]  req,
   input  logic [L2-1:0] ptr,
   output logic [L2-1:0] gnt,
   output logic          any
);

   always_comb begin
      int idx;
      gnt = '0;
      any = 1'b0;
      idx = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!any && req[idx]) begin
            any = 1'b1;
            gnt = L2'(idx);
         end
      end
   end

endmodule

// File: rtl/rx_buffer_arbiter.sv
// Read-side RX scheduler: round-robins ready channels and emits fixed
// 256-word packets (header, ACKed payload, zero pad) to the USB FIFO.
// Ports: clk/reset, packet_rdy, header/data FIFO q and ACKs, out_if stream,
// busy, pkt_count.
module rx_buffer_arbiter
   import inband_packet_defs::*;
#(
   parameter int NUM_CHAN = 4,
   parameter int CHAN_L2  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CHAN-1:0]    packet_rdy,
   input  logic [64*NUM_CHAN-1:0] i_header_data,
   input  logic [16*NUM_CHAN-1:0] i_chan_data,
   output logic [NUM_CHAN-1:0]    rd_header_en,
   output logic [NUM_CHAN-1:0]    rd_data_en,
   rx_buffer_arbiter_if.master    out_if,
   output logic                  busy,
   output logic [15:0]           pkt_count
);

   state_t             state_q, state_d;
   logic [CHAN_L2-1:0] grant_q, grant_d;
   logic [CHAN_L2-1:0] ptr_q, ptr_d;
   logic [7:0]         wcnt_q, wcnt_d;
   logic [7:0]         len_q, len_d;
   logic [15:0]        pcnt_q, pcnt_d;

   logic [CHAN_L2-1:0] arb_gnt;
   logic               arb_any;
   logic [63:0]        hdr_sel;
   logic [15:0]        dat_sel;
   logic [7:0]         hdr_len;
   logic               valid;
   logic               xfer;

   rr_arbiter #(
      .N  (NUM_CHAN),
      .L2 (CHAN_L2)
   ) u_rr (
      .req (packet_rdy),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .any (arb_any)
   );

   assign hdr_sel = i_header_data[int'(grant_q)*64 +: 64];
   assign dat_sel = i_chan_data[int'(grant_q)*16 +: 16];
   assign hdr_len = payload_words(hdr_sel[LEN_MSB:LEN_LSB]);

   assign valid = (state_q == ST_HDR) ||
                  (state_q == ST_DATA) ||
                  (state_q == ST_PAD);
   assign xfer  = valid && out_if.o_ready;

   assign out_if.o_valid = valid;
   assign out_if.o_sop   = valid && (wcnt_q == 8'd0);
   assign out_if.o_eop   = valid && (wcnt_q == 8'(PKT_WORDS-1));
   assign out_if.o_chan  = grant_q;
   assign busy           = (state_q != ST_IDLE);
   assign pkt_count      = pcnt_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      ptr_d        = ptr_q;
      wcnt_d       = wcnt_q;
      len_d        = len_q;
      pcnt_d       = pcnt_q;
      out_if.o_data = 16'd0;
      rd_header_en = '0;
      rd_data_en   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d = arb_gnt;
               wcnt_d  = 8'd0;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            out_if.o_data = hdr_sel[int'(wcnt_q[1:0])*16 +: 16];
            if (xfer) begin
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_q == 8'(HDR_WORDS-1)) begin
                  rd_header_en = NUM_CHAN'(1) << grant_q;
                  len_d        = hdr_len;
                  state_d      = (hdr_len != 8'd0) ? ST_DATA : ST_PAD;
               end
            end
         end
         ST_DATA: begin
            out_if.o_data = dat_sel;
            if (xfer) begin
               rd_data_en = NUM_CHAN'(1) << grant_q;
               wcnt_d     = wcnt_q + 8'd1;
               // Last payload word sits at index HDR_WORDS-1+len
               if (wcnt_q == len_q + 8'(HDR_WORDS-1)) begin
                  state_d = (wcnt_q == 8'(PKT_WORDS-1)) ? ST_DONE : ST_PAD;
               end
            end
         end
         ST_PAD: begin
            if (xfer) begin
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_q == 8'(PKT_WORDS-1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            pcnt_d  = pcnt_q + 16'd1;
            ptr_d   = (int'(grant_q) == NUM_CHAN-1) ? '0 : grant_q + 1'b1;
            wcnt_d  = 8'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wcnt_q  <= 8'd0;
         len_q   <= 8'd0;
         pcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
         pcnt_q  <= pcnt_d;
      end
   end

endmodule

// File: tb/tb_rx_buffer_arbiter.sv
// Directed bench for rx_buffer_arbiter with a show-ahead FIFO model
// per channel and a word monitor on the output stream.
module tb_rx_buffer_arbiter;

   localparam int NC = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NC-1:0]     packet_rdy;
   logic [64*NC-1:0]  i_header_data;
   logic [16*NC-1:0]  i_chan_data;
   logic [NC-1:0]     rd_header_en;
   logic [NC-1:0]     rd_data_en;
   logic              busy;
   logic [15:0]       pkt_count;

   rx_buffer_arbiter_if #(.CHAN_L2(2)) out_if ();

   rx_buffer_arbiter #(
      .NUM_CHAN (NC),
      .CHAN_L2  (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .packet_rdy    (packet_rdy),
      .i_header_data (i_header_data),
      .i_chan_data   (i_chan_data),
      .rd_header_en  (rd_header_en),
      .rd_data_en    (rd_data_en),
      .out_if        (out_if),
      .busy          (busy),
      .pkt_count     (pkt_count)
   );

   always #5 clk = ~clk;

   logic [63:0] hdr [NC];
   logic [11:0] dcnt [NC];
   bit          tog;

   always_comb begin
      for (int k = 0; k < NC; k++) begin
         i_header_data[64*k +: 64] = hdr[k];
         i_chan_data[16*k +: 16]   = {4'(k), dcnt[k]};
      end
   end

   // Data FIFO model: next word shows after each ACK
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NC; k++) dcnt[k] <= 12'd0;
      end else begin
         for (int k = 0; k < NC; k++)
            if (rd_data_en[k]) dcnt[k] <= dcnt[k] + 12'd1;
      end
   end

   initial begin
      out_if.o_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog) out_if.o_ready = ~out_if.o_ready;
         else out_if.o_ready = 1'b1;
      end
   end

   logic [15:0] words [$];
   int          chans [$];
   int          sops [$];
   int          eops [$];
   int          hdr_acks [NC];
   int          dat_acks [NC];
   int          bad_ack;

   always @(negedge clk) begin
      if (!reset) begin
         if (out_if.o_valid && out_if.o_ready) begin
            words.push_back(out_if.o_data);
            if (out_if.o_sop) begin
               sops.push_back(words.size());
               chans.push_back(int'(out_if.o_chan));
            end
            if (out_if.o_eop) eops.push_back(words.size());
         end
         for (int k = 0; k < NC; k++) begin
            if (rd_header_en[k]) hdr_acks[k]++;
            if (rd_data_en[k]) dat_acks[k]++;
         end
         if (rd_data_en != 0 && !out_if.o_ready) bad_ack++;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      words.delete();
      chans.delete();
      sops.delete();
      eops.delete();
      for (int k = 0; k < NC; k++) begin
         hdr_acks[k] = 0;
         dat_acks[k] = 0;
      end
      bad_ack = 0;
   endtask

   task automatic wait_sops(input int n);
      int c;
      c = 0;
      while (sops.size() < n && c < 3000) begin
         tick(1);
         c++;
      end
      chk("sop_wait", sops.size(), n);
   endtask

   task automatic wait_eops(input int n);
      int c;
      c = 0;
      while (eops.size() < n && c < 6000) begin
         tick(1);
         c++;
      end
      chk("eop_wait", eops.size(), n);
   endtask

   task automatic run_pkt(input int ch, input logic [8:0] fld, input bit t,
                          input string nm);
      int len, base, pc0, eh, ed, ep;
      logic [15:0] exp_w;
      clear_mon();
      hdr[ch] = {16'hA3A3, 16'hB2B2, 16'hC1C1, {7'h15, fld}};
      base = int'(dcnt[ch]);
      pc0 = int'(pkt_count);
      len = (int'(fld) + 1) / 2;
      if (len > 252) len = 252;
      tog = t;
      packet_rdy = 4'(1 << ch);
      wait_sops(1);
      packet_rdy = '0;
      wait_eops(1);
      tog = 1'b0;
      tick(3);
      eh = 0;
      ed = 0;
      ep = 0;
      for (int i = 0; i < words.size() && i < 256; i++) begin
         if (i < 4) begin
            exp_w = hdr[ch][16*i +: 16];
            if (words[i] !== exp_w) eh++;
         end else if (i < 4 + len) begin
            exp_w = {4'(ch), 12'(base + i - 4)};
            if (words[i] !== exp_w) ed++;
         end else begin
            if (words[i] !== 16'd0) ep++;
         end
      end
      chk({nm, "_words"}, words.size(), 256);
      chk({nm, "_sop"}, sops[0], 1);
      chk({nm, "_eop"}, eops[0], 256);
      chk({nm, "_chan"}, chans[0], ch);
      chk({nm, "_hdr_err"}, eh, 0);
      chk({nm, "_dat_err"}, ed, 0);
      chk({nm, "_pad_err"}, ep, 0);
      chk({nm, "_hdr_ack"}, hdr_acks[ch], 1);
      chk({nm, "_dat_ack"}, dat_acks[ch], len);
      chk({nm, "_bad_ack"}, bad_ack, 0);
      chk({nm, "_pkt_cnt"}, pkt_count, 16'(pc0 + 1));
      chk({nm, "_busy"}, busy, 0);
   endtask

   task automatic run_seq(input logic [NC-1:0] rdy, input int n);
      clear_mon();
      for (int k = 0; k < NC; k++) hdr[k] = 64'h0;
      packet_rdy = rdy;
      wait_sops(n);
      packet_rdy = '0;
      wait_eops(n);
      tick(3);
   endtask

   initial begin
      int c;
      reset = 1'b1;
      packet_rdy = '0;
      tog = 1'b0;
      for (int k = 0; k < NC; k++) hdr[k] = 64'h0;
      clear_mon();
      tick(2);
      chk("rst_valid", out_if.o_valid, 0);
      chk("rst_data", out_if.o_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_count, 0);
      reset = 1'b0;
      tick(2);

      run_pkt(0, 9'd504, 1'b0, "full");
      run_pkt(0, 9'd7, 1'b0, "odd7");
      run_pkt(0, 9'd504, 1'b1, "toggle");
      run_pkt(0, 9'd0, 1'b0, "zero");

      // Reset in the middle of the payload
      clear_mon();
      hdr[0] = {48'h0, 16'h01F8};
      packet_rdy = 4'b0001;
      c = 0;
      while (dat_acks[0] < 100 && c < 1000) begin
         tick(1);
         c++;
      end
      chk("mid_reach", dat_acks[0] >= 100, 1);
      reset = 1'b1;
      #1;
      chk("mid_valid", out_if.o_valid, 0);
      chk("mid_data", out_if.o_data, 0);
      chk("mid_sop_eop", {out_if.o_sop, out_if.o_eop}, 0);
      chk("mid_chan", out_if.o_chan, 0);
      chk("mid_rd_en", {rd_header_en, rd_data_en}, 0);
      chk("mid_busy", busy, 0);
      chk("mid_pkt_cnt", pkt_count, 0);
      packet_rdy = '0;
      tick(2);
      reset = 1'b0;
      tick(2);
      chk("post_busy", busy, 0);

      // Pointer back at 0: channel 0 wins over 1
      run_seq(4'b0011, 1);
      chk("ptr0_chan", chans[0], 0);
      chk("ptr0_cnt", pkt_count, 1);

      // Channels 1 and 3 alternate
      run_seq(4'b1010, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_chan%0d", i), chans[i], (i % 2 == 0) ? 1 : 3);
         chk($sformatf("rr_eop%0d", i), eops[i], 256 * (i + 1));
      end
      chk("rr_words", words.size(), 1024);
      chk("rr_cnt", pkt_count, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
